tcs3200_emulator: RTL and testbench
===================================

Name: tcs3200_emulator

Overview:
- Synthesizable model of the TCS3200 colour sensor, driven from the FPGA side.
- Takes the S0..S3 control lines a colour-sensor core drives and produces a square-wave `sensor_out` whose frequency depends on the selected filter and output scaling.
- Per-channel frequencies are loaded through a valid/ready config port, so the sorter can run hardware-in-loop on a bench without a physical sensor or coloured objects.

Parameters:
- DEF_HALF_R, 6000: reset half-period (clk cycles, 100% scaling) of the red channel.
- DEF_HALF_G, 20000: reset half-period of the green channel.
- DEF_HALF_B, 20000: reset half-period of the blue channel.
- DEF_HALF_C, 3000: reset half-period of the clear channel.
- SETTLE_CYCLES, 12500: output-quiet time after any S0..S3 change (100 us at 125 MHz).

Ports:
- clk  in  1  system clock, 125 MHz; single clock domain.
- rst_n  in  1  reset; synchronous, active-high (asserted = 1) despite the name.
- s0, s1  in  1 each  scaling select: 00 power-down, 01 2%, 10 20%, 11 100%.
- s2, s3  in  1 each  filter select: 00 red, 01 blue, 10 clear, 11 green.
- sensor_out  out  1  emulated frequency output.
- sensor_oe  out  1  1 when the output is driven; 0 in power-down.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when valid & ready.
- cfg_sel  in  2  channel to write; same encoding as {s2,s3}.
- cfg_half  in  24  new base half-period in clk cycles; 0 means dark (no edges).
- pulse_cnt  out  16  rising edges of sensor_out since the last filter/scaling change; saturates at 65535.
- settling  out  1  high while in SETTLE.

Behaviour:
- **Reset** (rst_n=1 at a clk edge):
  - Outputs: sensor_out=0, sensor_oe=0, pulse_cnt=0, settling=0, cfg_ready=1.
  - Half registers load DEF_HALF_*.
  - State becomes OFF; the input-sync history is cleared to 00 00.
  - Reset mid-operation aborts everything, including a pending config write.
- **Input synchronisation:** S0..S3 pass through a 2-flop synchroniser. A change is detected when the synchronised value differs from the previous synchronised value. Effect appears at the outputs 3 cycles after an input change.
- **Effective half-period:** eff = base × factor, where factor is 1 (11), 5 (10), 50 (01). Width is 30 bits; no overflow is possible (max 2^24 × 50 < 2^30).
- **States:**
  - OFF (scaling 00)
    - sensor_out=0, sensor_oe=0, half counter held at 0.
  - SETTLE
    - sensor_oe=1, sensor_out=0, settling=1; counts SETTLE_CYCLES cycles.
    - Then goes to RUN_HI, or to DARK if the selected eff=0.
  - RUN_HI / RUN_LO
    - sensor_out=1 / 0. The counter counts eff cycles, then the state toggles.
    - Entering RUN_HI increments pulse_cnt.
    - eff is re-evaluated at every toggle.
  - DARK
    - sensor_out=0. Leaves to RUN_HI at the cycle eff becomes nonzero.
- **Transitions:**
  - Any synchronised S-change with scaling ≠ 00 goes to SETTLE, clears pulse_cnt and restarts the settle count (back-to-back changes extend settling).
  - Scaling → 00 goes to OFF from any state immediately.
  - Leaving OFF always passes through SETTLE.
- **Config port:**
  - A write to a channel that is not currently selected commits next cycle.
  - A write to the selected channel in RUN_HI/RUN_LO is held pending and commits at the next toggle boundary, so the current phase never has a glitched length.
  - cfg_ready=0 from the cycle after acceptance until commit.
  - In OFF, SETTLE or DARK, a write to the selected channel commits next cycle.
  - If an S-change and a pending commit coincide, the commit happens first, then SETTLE.
  - The RUN_HI entry that a config commit causes from DARK counts as a pulse.
- **pulse_cnt:** saturates at 65535 and holds; it is not a wrap counter.

Test Plan:
- Reset, SETTLE_CYCLES=8, cfg writes R=5, G=3, S=11 00 → after 3 sync + 8 settle cycles, sensor_out high 5 / low 5 repeating. pulse_cnt=10 after 100 further cycles.
- Same setup, S=10 00 (20%) → phases of 25 cycles. Switch to S=11 11 → settling=1 for 8 cycles, pulse_cnt=0, then 3-cycle phases.
- Running on green (half=3), write G=7 mid-phase → cfg_ready=0 until the next toggle, current phase stays 3 cycles, following phases are 7 cycles.
- Write C=0, select clear → sensor_out stays 0 and pulse_cnt stays 0 for 200 cycles. Write C=4 → next cycle RUN_HI with 4-cycle phases, pulse_cnt=1.
- S0S1=00 while running → within 3 cycles sensor_oe=0 and sensor_out=0. Restore 11 → SETTLE for 8 cycles, then toggling.
- Assert rst_n=1 for 1 cycle mid-RUN_HI with a pending write → all outputs take reset values, the pending write is discarded and the DEF_HALF_* values are restored.

Source files
------------

// File: rtl/tcs3200_emulator.sv
// TCS3200 colour-sensor emulator: S0..S3 select a filter/scaling, sensor_out is a
// square wave whose half-period is the channel's programmed base times the scaling factor.
module tcs3200_emulator #(
  parameter int unsigned DEF_HALF_R    = 6000,
  parameter int unsigned DEF_HALF_G    = 20000,
  parameter int unsigned DEF_HALF_B    = 20000,
  parameter int unsigned DEF_HALF_C    = 3000,
  parameter int unsigned SETTLE_CYCLES = 12500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s0,
  input  logic        s1,
  input  logic        s2,
  input  logic        s3,
  output logic        sensor_out,
  output logic        sensor_oe,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_sel,
  input  logic [23:0] cfg_half,
  output logic [15:0] pulse_cnt,
  output logic        settling
);

  typedef enum logic [2:0] {OFF, SETTLE, RUN_HI, RUN_LO, DARK} state_t;

  localparam logic [29:0] SETTLE_LAST = 30'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [3:0]       s_meta, s_sync, s_prev;
  logic [3:0][23:0] half_q, half_nxt;
  logic             pend_vld;
  logic [1:0]       pend_sel;
  logic [23:0]      pend_half;
  logic [29:0]      cnt, eff_cur, eff_nxt;
  logic [1:0]       scale, filt;
  logic [15:0]      pulse_inc;
  logic             change, running, phase_end, accept, defer, commit_pend;

  function automatic logic [29:0] scaled(input logic [23:0] h, input logic [1:0] sc);
    case (sc)
      2'b11:   scaled = 30'(h);
      2'b10:   scaled = 30'(h) * 30'd5;
      2'b01:   scaled = 30'(h) * 30'd50;
      default: scaled = '0;
    endcase
  endfunction

  // Channel index is the filter code {s2,s3}: 0 red, 1 blue, 2 clear, 3 green.
  assign scale     = s_sync[3:2];
  assign filt      = s_sync[1:0];
  assign change    = (s_sync != s_prev);
  assign running   = (state == RUN_HI) || (state == RUN_LO);
  assign eff_cur   = scaled(half_q[filt], scale);
  assign phase_end = running && (cnt == eff_cur - 30'd1);
  assign cfg_ready = ~pend_vld;
  assign accept    = cfg_valid && cfg_ready;
  // A live write to the running channel waits for the phase boundary.
  assign defer       = accept && running && (cfg_sel == filt) && !change;
  assign commit_pend = pend_vld && (phase_end || change);
  assign pulse_inc   = (pulse_cnt == 16'hFFFF) ? pulse_cnt : pulse_cnt + 16'd1;

  always_comb begin
    half_nxt = half_q;
    if (commit_pend) half_nxt[pend_sel] = pend_half;
    if (accept && !defer) half_nxt[cfg_sel] = cfg_half;
  end

  assign eff_nxt = scaled(half_nxt[filt], scale);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s_meta     <= '0;
      s_sync     <= '0;
      s_prev     <= '0;
      half_q     <= {24'(DEF_HALF_G), 24'(DEF_HALF_C), 24'(DEF_HALF_B), 24'(DEF_HALF_R)};
      pend_vld   <= 1'b0;
      pend_sel   <= '0;
      pend_half  <= '0;
      state      <= OFF;
      cnt        <= '0;
      sensor_out <= 1'b0;
      sensor_oe  <= 1'b0;
      settling   <= 1'b0;
      pulse_cnt  <= '0;
    end else begin
      s_meta <= {s0, s1, s2, s3};
      s_sync <= s_meta;
      s_prev <= s_sync;
      half_q <= half_nxt;

      if (defer) begin
        pend_vld  <= 1'b1;
        pend_sel  <= cfg_sel;
        pend_half <= cfg_half;
      end else if (commit_pend) begin
        pend_vld <= 1'b0;
      end

      if (scale == 2'b00) begin
        state      <= OFF;
        cnt        <= '0;
        sensor_out <= 1'b0;
        sensor_oe  <= 1'b0;
        settling   <= 1'b0;
        if (change) pulse_cnt <= '0;
      end else if (change) begin
        state      <= SETTLE;
        cnt        <= '0;
        sensor_out <= 1'b0;
        sensor_oe  <= 1'b1;
        settling   <= 1'b1;
        pulse_cnt  <= '0;
      end else begin
        case (state)
          SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              cnt      <= '0;
              settling <= 1'b0;
              if (eff_nxt == '0) begin
                state <= DARK;
              end else begin
                state      <= RUN_HI;
                sensor_out <= 1'b1;
                pulse_cnt  <= pulse_inc;
              end
            end else begin
              cnt <= cnt + 30'd1;
            end
          end
          RUN_HI: begin
            if (phase_end) begin
              cnt        <= '0;
              sensor_out <= 1'b0;
              state      <= (eff_nxt == '0) ? DARK : RUN_LO;
            end else begin
              cnt <= cnt + 30'd1;
            end
          end
          RUN_LO: begin
            if (phase_end) begin
              cnt <= '0;
              if (eff_nxt == '0) begin
                state <= DARK;
              end else begin
                state      <= RUN_HI;
                sensor_out <= 1'b1;
                pulse_cnt  <= pulse_inc;
              end
            end else begin
              cnt <= cnt + 30'd1;
            end
          end
          DARK: begin
            if (eff_nxt != '0) begin
              cnt        <= '0;
              state      <= RUN_HI;
              sensor_out <= 1'b1;
              pulse_cnt  <= pulse_inc;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tcs3200_emulator.sv
// Scoreboard bench for tcs3200_emulator: a phase-countdown reference model queues the
// expected outputs of every clock; a monitor pops and compares them on the falling edge.
module tb_tcs3200_emulator;

  localparam int SETTLE = 8;
  localparam int DR = 6, DG = 9, DB = 7, DC = 3;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        s0 = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [23:0] cfg_half = '0;
  logic        sensor_out, sensor_oe, cfg_ready, settling;
  logic [15:0] pulse_cnt;

  tcs3200_emulator #(
    .DEF_HALF_R(DR), .DEF_HALF_G(DG), .DEF_HALF_B(DB), .DEF_HALF_C(DC),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .sensor_out(sensor_out), .sensor_oe(sensor_oe),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_half(cfg_half),
    .pulse_cnt(pulse_cnt), .settling(settling)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        out;
    logic        oe;
    logic        st;
    logic        rdy;
    logic [15:0] pc;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0, bad = 0;

  // Reference model: mode plus cycles left in the current phase.
  localparam int M_OFF = 0, M_SETTLE = 1, M_HI = 2, M_LO = 3, M_DARK = 4;
  int         mode = M_OFF, left = 0, pulses = 0;
  int         half[4] = '{DR, DB, DC, DG};
  bit         pend = 1'b0;
  int         psel = 0, phalf = 0;
  logic [3:0] dly[3] = '{default: 4'd0};
  bit         m_ready = 1'b1;

  function automatic int factor(input logic [1:0] sc);
    return (sc == 2'b11) ? 1 : (sc == 2'b10) ? 5 : (sc == 2'b01) ? 50 : 0;
  endfunction

  function automatic void enter_run(input int e);
    if (e == 0) begin
      mode = M_DARK;
    end else begin
      mode   = M_HI;
      left   = e;
      pulses = (pulses >= 65535) ? 65535 : pulses + 1;
    end
  endfunction

  always @(posedge clk) begin : model
    logic [3:0] cur, prv;
    bit         chg, run, tog, acc;
    int         e;
    obs_t       o;
    if (rst_n) begin
      mode = M_OFF; left = 0; pulses = 0; pend = 1'b0;
      half = '{DR, DB, DC, DG};
      dly  = '{default: 4'd0};
    end else begin
      cur = dly[1];
      prv = dly[2];
      chg = (cur != prv);
      run = (mode == M_HI) || (mode == M_LO);
      tog = run && (left == 1);
      acc = cfg_valid && !pend;
      if (pend && (tog || chg)) begin
        half[psel] = phalf;
        pend = 1'b0;
      end
      if (acc) begin
        if (run && (int'(cfg_sel) == int'(cur[1:0])) && !chg) begin
          pend = 1'b1; psel = int'(cfg_sel); phalf = int'(cfg_half);
        end else begin
          half[cfg_sel] = int'(cfg_half);
        end
      end
      e = half[cur[1:0]] * factor(cur[3:2]);
      if (cur[3:2] == 2'b00) begin
        mode = M_OFF;
        if (chg) pulses = 0;
      end else if (chg) begin
        mode = M_SETTLE; left = SETTLE; pulses = 0;
      end else begin
        case (mode)
          M_SETTLE: if (left == 1) enter_run(e); else left--;
          M_HI: begin
            if (tog) begin
              if (e == 0) mode = M_DARK;
              else begin mode = M_LO; left = e; end
            end else left--;
          end
          M_LO:   if (tog) enter_run(e); else left--;
          M_DARK: if (e != 0) enter_run(e);
          default: ;
        endcase
      end
      dly[2] = dly[1];
      dly[1] = dly[0];
      dly[0] = {s0, s1, s2, s3};
    end
    m_ready = !pend;
    o.out = (mode == M_HI);
    o.oe  = (mode != M_OFF);
    o.st  = (mode == M_SETTLE);
    o.rdy = !pend;
    o.pc  = 16'(pulses);
    exp_q.push_back(o);
  end

  always @(negedge clk) begin : monitor
    obs_t a, w;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      a = {sensor_out, sensor_oe, settling, cfg_ready, pulse_cnt};
      total++;
      if (a !== w) begin
        bad++;
        $display("FAIL outputs t=%0t got/want: out=%b/%b oe=%b/%b settling=%b/%b ready=%b/%b pulse_cnt=%0d/%0d",
                 $time, a.out, w.out, a.oe, w.oe, a.st, w.st, a.rdy, w.rdy, a.pc, w.pc);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_s(input logic [3:0] v);
    {s0, s1, s2, s3} = v;
  endtask

  task automatic cfg_wr(input logic [1:0] sel, input int h);
    int guard = 0;
    while (!m_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!m_ready) begin
      total++; bad++;
      $display("FAIL cfg_wait ready=0 want 1 after %0d cycles", guard);
    end else begin
      cfg_valid = 1'b1; cfg_sel = sel; cfg_half = 24'(h);
      @(negedge clk);
      cfg_valid = 1'b0;
    end
  endtask

  task automatic pulse_rst();
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    cyc(2);
    rst_n = 1'b0;
    // 100% on red, then 20%, then green
    cfg_wr(2'd0, 5); cfg_wr(2'd3, 3);
    set_s(4'b1100); cyc(120);
    set_s(4'b1000); cyc(120);
    set_s(4'b1111); cyc(40);
    // live write to the running channel
    cyc(1); cfg_wr(2'd3, 7); cyc(40);
    // dark clear channel, then wake it up
    cfg_wr(2'd2, 0); set_s(4'b1110); cyc(200);
    cfg_wr(2'd2, 4); cyc(30);
    // power-down and back
    set_s(4'b0010); cyc(10);
    set_s(4'b1110); cyc(30);
    // reset with a pending write
    cyc(2); cfg_wr(2'd2, 9); pulse_rst(); cyc(40);
    // randomized traffic
    for (int i = 0; i < 90; i++) begin
      int k;
      k = int'($urandom_range(0, 9));
      if (k < 4) begin
        set_s({($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3)), 2'($urandom_range(0, 3))});
      end else if (k < 8) begin
        cfg_wr(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12)));
      end else if (k == 8) begin
        pulse_rst();
      end
      cyc(int'($urandom_range(1, 50)));
    end
    cyc(3);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
